// File: rtl/arb_bram.sv
// Round-robin arbiter in front of a single-port synchronous RAM.
// Each granted operation runs IDLE -> ACCESS -> RESP and pulses ack for one cycle.
module arb_bram #(
  parameter int DATA     = 8,
  parameter int ADDR     = 15,
  parameter int CHANNELS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNELS-1:0]      req,
  input  logic [CHANNELS-1:0]      wr,
  input  logic [CHANNELS*ADDR-1:0] addr,
  input  logic [CHANNELS*DATA-1:0] din,
  output logic [CHANNELS-1:0]      ack,
  output logic [DATA-1:0]          dout,
  output logic                     busy
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   cand;
  logic            pick_ok;
  logic [IW-1:0]   g_idx;
  logic            g_wr;
  logic [ADDR-1:0] g_addr;
  logic [DATA-1:0] g_din;

  logic [DATA-1:0] mem [0:(2**ADDR)-1];

  // Round-robin search starting one past the previous winner.
  always_comb begin
    pick    = '0;
    cand    = '0;
    pick_ok = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IW'((int'(last_grant) + i + 32'sd1) % CHANNELS);
      if (!pick_ok && req[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end else begin
        pick    = pick;
        pick_ok = pick_ok;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, grant capture, ack pulse and read-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IW'(CHANNELS - 1);
      g_idx      <= '0;
      g_wr       <= 1'b0;
      g_addr     <= '0;
      g_din      <= '0;
      ack        <= '0;
      dout       <= '0;
    end else begin
      state <= state_nxt;
      ack   <= '0;
      if (state == IDLE && pick_ok) begin
        last_grant <= pick;
        g_idx      <= pick;
        g_wr       <= wr[pick];
        g_addr     <= addr[pick*ADDR +: ADDR];
        g_din      <= din[pick*DATA +: DATA];
      end
      if (state == ACCESS) begin
        ack[g_idx] <= 1'b1;
        if (!g_wr) begin
          dout <= mem[g_addr];
        end
      end
    end
  end

  // RAM write port; reset pulls state out of ACCESS so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && g_wr) begin
      mem[g_addr] <= g_din;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_arb_bram.sv
// Directed bench for arb_bram: stimulus pushes expected acks into a queue,
// a negedge monitor pops and compares channel and dout on every ack.
module tb_arb_bram;

  localparam int DATA = 8;
  localparam int ADDR = 15;
  localparam int CH   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [CH-1:0]      req;
  logic [CH-1:0]      wr;
  logic [CH*ADDR-1:0] addr;
  logic [CH*DATA-1:0] din;
  logic [CH-1:0]      ack;
  logic [DATA-1:0]    dout;
  logic               busy;

  arb_bram #(.DATA(DATA), .ADDR(ADDR), .CHANNELS(CH)) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .addr(addr),
    .din(din), .ack(ack), .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic [7:0] d;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         ack_cyc[$];
  logic [7:0] held;
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: every ack must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && ack != '0) begin
      ack_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_ack", {28'd0, ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_channel", {28'd0, ack}, 32'd1 << mon_e.ch);
        check("dout", {24'd0, dout}, {24'd0, mon_e.d});
      end
    end
  end

  task automatic set_ch(int c, logic w, logic [ADDR-1:0] a, logic [7:0] d);
    wr[c]                = w;
    addr[c*ADDR +: ADDR] = a;
    din[c*DATA +: DATA]  = d;
  endtask

  // Writes must leave dout holding the last read value.
  task automatic expect_op(int c, logic w, logic [7:0] rd);
    exp_t e;
    e.ch = c;
    e.d  = w ? held : rd;
    if (!w) held = rd;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    req  = '0;
    rst  = 1'b1;
    held = 8'h00;
    sb.delete();
    @(posedge clk); #1;
    check("rst_ack", {28'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dout", {24'd0, dout}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_ack(int c, string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!ack[c] && n < 20);
    check(name, {31'd0, ack[c]}, 32'd1);
  endtask

  task automatic wait_busy(string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!busy && n < 20);
    check(name, {31'd0, busy}, 32'd1);
  endtask

  task automatic do_op(int c, logic w, logic [ADDR-1:0] a, logic [7:0] d, logic [7:0] rd);
    set_ch(c, w, a, d);
    expect_op(c, w, rd);
    req[c] = 1'b1;
    wait_ack(c, "op_ack_seen");
    req[c] = 1'b0;
  endtask

  initial begin
    int n;
    int k;
    int b;
    rst  = 1'b1;
    req  = '0;
    wr   = '0;
    addr = '0;
    din  = '0;
    held = 8'h00;
    @(posedge clk); #1;
    do_reset();

    // Preload and the ch1 write-then-read sequence.
    do_op(2, 1'b1, 15'h0010, 8'h5A, 8'h00);
    do_op(1, 1'b1, 15'h0123, 8'hA5, 8'h00);
    do_op(1, 1'b0, 15'h0123, 8'h00, 8'hA5);
    do_op(0, 1'b1, 15'h7FFF, 8'h11, 8'h00);

    // All four channels read at once after reset: served 0,1,2,3, three cycles apart.
    do_reset();
    set_ch(0, 1'b0, 15'h0123, 8'h00);
    set_ch(1, 1'b0, 15'h0010, 8'h00);
    set_ch(2, 1'b0, 15'h7FFF, 8'h00);
    set_ch(3, 1'b0, 15'h0123, 8'h00);
    expect_op(0, 1'b0, 8'hA5);
    expect_op(1, 1'b0, 8'h5A);
    expect_op(2, 1'b0, 8'h11);
    expect_op(3, 1'b0, 8'hA5);
    b   = ack_cyc.size();
    req = 4'hF;
    n   = 0;
    while (req != 4'h0 && n < 40) begin
      @(posedge clk); #1;
      req = req & ~ack;
      n++;
    end
    check("all_served", {28'd0, req}, 32'd0);
    @(negedge clk); #1;
    check("ack_count4", ack_cyc.size() - b, 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (ack_cyc.size() > b + i) check("ack_spacing", ack_cyc[b+i] - ack_cyc[b+i-1], 32'd3);
    end

    // Read with req dropped after grant and address changed: captured values win.
    set_ch(2, 1'b0, 15'h0010, 8'h00);
    expect_op(2, 1'b0, 8'h5A);
    req[2] = 1'b1;
    wait_busy("grant_ch2");
    req[2] = 1'b0;
    set_ch(2, 1'b0, 15'h0123, 8'h00);
    wait_ack(2, "dropped_req_ack");
    do_op(1, 1'b1, 15'h0200, 8'h77, 8'h00);

    // Fairness: ch0 holds req, ch2 arrives -> ch0, ch2, ch0.
    do_reset();
    set_ch(0, 1'b0, 15'h0123, 8'h00);
    set_ch(2, 1'b0, 15'h0010, 8'h00);
    expect_op(0, 1'b0, 8'hA5);
    expect_op(2, 1'b0, 8'h5A);
    expect_op(0, 1'b0, 8'hA5);
    req[0] = 1'b1;
    wait_busy("grant_ch0");
    req[2] = 1'b1;
    k = 0;
    n = 0;
    while (k < 3 && n < 40) begin
      @(posedge clk); #1;
      if (ack != '0) k++;
      if (ack[2]) req[2] = 1'b0;
      if (k == 3) req[0] = 1'b0;
      n++;
    end
    check("fair_acks", k, 32'd3);
    req = '0;

    // Reset during ACCESS aborts a ch3 write of 0x3C to 0x7FFF.
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_ch(3, 1'b1, 15'h7FFF, 8'h3C);
    req[3] = 1'b1;
    wait_busy("grant_ch3");
    rst  = 1'b1;
    held = 8'h00;
    #1;
    check("abort_ack", {28'd0, ack}, 32'd0);
    check("abort_dout", {24'd0, dout}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("abort_ack_edge", {28'd0, ack}, 32'd0);
    req[3] = 1'b0;
    rst    = 1'b0;
    do_op(3, 1'b0, 15'h7FFF, 8'h00, 8'h11);

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
